// File: rtl/fpu_pkg.sv
// Shared FPU-side definitions: op codes, canonical quiet NaN, arbiter state.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fpu_pkg;

  localparam logic [2:0] FPU_OP_ADD = 3'b000;
  localparam logic [2:0] FPU_OP_SUB = 3'b001;
  localparam logic [2:0] FPU_OP_MUL = 3'b010;
  localparam logic [2:0] FPU_OP_DIV = 3'b011;

  // Returned in place of a real result when the FPU never answers.
  localparam logic [31:0] FPU_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpu_rr_pick.sv
// Round-robin pick: first set request at index >= ptr, wrapping past N-1.
// Latency: combinational.
// Backpressure: none; caller decides when to act on the pick.
// Ports: req (N requests), ptr (search start) -> gnt (one-hot), idx, vld.
module fpu_rr_pick
  import fpu_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          vld
);

  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!vld && req[j]) begin
        vld    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fpu_arbiter.sv
// Round-robin front end for one shared FPU: grant, issue one req pulse, wait ack, return result.
// Latency: req_i sampled cycle n -> fpu_req n+1 -> ack_o n+4 with a 2-cycle FPU; one op per 5 cycles max.
// Backpressure: requesters hold req_i until ack_o; FPU paced by fpu_ack; no new grant until DONE passes.
// Ports: req_i/op_a_i/op_b_i/op_i per requester in, ack_o one-hot + shared result_o out,
//   timeout_o watchdog pulse, fpu_req/fpu_op_a/fpu_op_b/fpu_op to FPU, fpu_ack/fpu_result back.
// Optional: FPU_ARB_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT_CYCLES returning FPU_QNAN.
module fpu_arbiter
  import fpu_pkg::*;
#(
  parameter int NUM_REQ = 2
`ifdef FPU_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 15
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [32*NUM_REQ-1:0]  op_a_i,
  input  logic [32*NUM_REQ-1:0]  op_b_i,
  input  logic [3*NUM_REQ-1:0]   op_i,
  output logic [NUM_REQ-1:0]     ack_o,
  output logic [31:0]            result_o,
  output logic                   timeout_o,
  output logic                   fpu_req,
  output logic [31:0]            fpu_op_a,
  output logic [31:0]            fpu_op_b,
  output logic [2:0]             fpu_op,
  input  logic                   fpu_ack,
  input  logic [31:0]            fpu_result
);

  localparam int IW = idx_w(NUM_REQ);

  arb_state_e         state;
  logic [IW-1:0]      ptr;
  logic [NUM_REQ-1:0] gnt_q;     // winner of the op in flight

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_vld;

  fpu_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req (req_i),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .vld (pick_vld)
  );

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
`else
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      ptr      <= '0;
      gnt_q    <= '0;
      ack_o    <= '0;
      result_o <= '0;
      fpu_req  <= 1'b0;
      fpu_op_a <= '0;
      fpu_op_b <= '0;
      fpu_op   <= '0;
`ifdef FPU_ARB_TIMEOUT_EN
      timeout_o <= 1'b0;
      wait_cnt  <= '0;
`endif
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_vld) begin
            // Operands are captured here so later changes on op_*_i cannot leak in.
            gnt_q    <= pick_gnt;
            fpu_op_a <= op_a_i[32*pick_idx +: 32];
            fpu_op_b <= op_b_i[32*pick_idx +: 32];
            fpu_op   <= op_i[3*pick_idx +: 3];
            fpu_req  <= 1'b1;
            ptr      <= (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
            state    <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          // The FPU captures on level, so the request must drop after one cycle.
          fpu_req <= 1'b0;
          state   <= ARB_WAIT;
`ifdef FPU_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ARB_WAIT: begin
          if (fpu_ack) begin
            result_o <= fpu_result;
            ack_o    <= gnt_q;
            state    <= ARB_DONE;
          end
`ifdef FPU_ARB_TIMEOUT_EN
          else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            result_o  <= FPU_QNAN;
            ack_o     <= gnt_q;
            timeout_o <= 1'b1;
            state     <= ARB_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        ARB_DONE: begin
          // Requests are ignored here so a winner's registered deassert cannot re-issue.
          ack_o <= '0;
`ifdef FPU_ARB_TIMEOUT_EN
          timeout_o <= 1'b0;
`endif
          state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: 2 requesters, 2-cycle FPU model, timeline reference model.
// Latency: n/a.
// Backpressure: requesters hold req until their ack pulse.
module tb_fpu_arbiter;
  import fpu_pkg::*;

  localparam int NREQ = 2;
  localparam int TO   = 15;
`ifdef FPU_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_i = '0;
  logic [32*NREQ-1:0] op_a_i = '0;
  logic [32*NREQ-1:0] op_b_i = '0;
  logic [3*NREQ-1:0] op_i = '0;
  logic [NREQ-1:0]   ack_o;
  logic [31:0]       result_o;
  logic              timeout_o;
  logic              fpu_req;
  logic [31:0]       fpu_op_a, fpu_op_b;
  logic [2:0]        fpu_op;
  logic              fpu_ack = 1'b0;
  logic [31:0]       fpu_result = '0;

  fpu_arbiter #(.NUM_REQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .op_a_i(op_a_i), .op_b_i(op_b_i), .op_i(op_i),
    .ack_o(ack_o), .result_o(result_o), .timeout_o(timeout_o),
    .fpu_req(fpu_req), .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b), .fpu_op(fpu_op),
    .fpu_ack(fpu_ack), .fpu_result(fpu_result)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- IEEE single <-> real (normal numbers) ----------------
  function automatic real f2r(input logic [31:0] f);
    real m;
    int  ex;
    if (f[30:0] == 31'd0) return 0.0;
    m  = 1.0 + real'(f[22:0]) / 8388608.0;
    ex = int'(f[30:23]) - 127;
    m  = m * (2.0 ** ex);
    return f[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real v);
    logic        s;
    int          ex;
    real         m;
    logic [22:0] fr;
    if (v == 0.0) return 32'd0;
    s  = (v < 0.0);
    m  = s ? -v : v;
    ex = 0;
    while (m >= 2.0) begin m = m / 2.0; ex++; end
    while (m < 1.0)  begin m = m * 2.0; ex--; end
    fr = 23'($rtoi((m - 1.0) * 8388608.0 + 0.5));
    return {s, 8'(ex + 127), fr};
  endfunction

  function automatic logic [31:0] fpu_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    real x, y, r;
    x = f2r(a);
    y = f2r(b);
    case (op)
      FPU_OP_ADD: r = x + y;
      FPU_OP_SUB: r = x - y;
      FPU_OP_MUL: r = x * y;
      default:    r = x / y;
    endcase
    return r2f(r);
  endfunction

  // ---------------- FPU model: ack two cycles after the req cycle ----------------
  bit          fpu_en = 1'b1;
  int          spur_req = 0;
  int          spur_done = 0;
  int          pend = 0;
  logic [31:0] pend_res = '0;

  always @(posedge clk) begin
    #1;
    fpu_ack = 1'b0;
    if (!rst_n) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          fpu_ack    = 1'b1;
          fpu_result = pend_res;
        end
      end
      if (spur_done != spur_req) begin
        spur_done  = spur_req;
        fpu_ack    = 1'b1;
        fpu_result = 32'h1234_5678;
      end
      if (fpu_req && fpu_en) begin
        pend     = 2;
        pend_res = fpu_calc(fpu_op, fpu_op_a, fpu_op_b);
      end
    end
  end

  // ---------------- requesters: hold req until own ack count reached ----------------
  int ops_total[NREQ] = '{default: 0};
  int ops_done[NREQ]  = '{default: 0};

  always @(negedge clk) begin
    for (int k = 0; k < NREQ; k++) begin
      if (rst_n && ack_o[k]) ops_done[k]++;
      req_i[k] = (ops_done[k] < ops_total[k]);
    end
  end

  // ---------------- reference model: event timeline per edge ----------------
  int          e = 0;
  bit          m_busy = 1'b0;
  int          m_ptr = 0;
  int          m_win = 0;
  int          m_issue_e = -10;
  int          m_wait_e = 0;
  int          m_ack_e = -10;
  int          m_to_e = -10;
  int          m_idle_e = 0;
  logic [31:0] m_res = '0;
  logic [31:0] m_a = '0, m_b = '0;
  logic [2:0]  m_op = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_ptr = 0; m_issue_e = -10; m_ack_e = -10; m_to_e = -10;
      m_idle_e = 0; m_res = '0;
    end else begin
      e++;
      if (!m_busy && e >= m_idle_e && (|req_i)) begin
        bit found;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
          if (!found && req_i[(m_ptr + i) % NREQ]) begin
            found = 1'b1;
            m_win = (m_ptr + i) % NREQ;
          end
        end
        m_ptr     = (m_win + 1) % NREQ;
        m_a       = op_a_i[m_win*32 +: 32];
        m_b       = op_b_i[m_win*32 +: 32];
        m_op      = op_i[m_win*3 +: 3];
        m_issue_e = e;
        m_wait_e  = e + 2;
        m_busy    = 1'b1;
      end else if (m_busy && e >= m_wait_e) begin
        if (fpu_ack) begin
          m_res = fpu_result; m_ack_e = e; m_busy = 1'b0; m_idle_e = e + 2;
        end else if (TO_EN && (e - m_wait_e) == TO - 1) begin
          m_res = FPU_QNAN; m_ack_e = e; m_to_e = e; m_busy = 1'b0; m_idle_e = e + 2;
        end
      end
    end
  end

  // ---------------- per-cycle compare + logs ----------------
  int          ack_log[$];
  logic [31:0] res_log[$];
  int          ack_e_log[$];
  int          req_e_log[$];
  int          to_count = 0;
  int          run = 0;
  int          max_run = 0;

  always @(negedge clk) begin
    logic [NREQ-1:0] ea;
    ea = (e == m_ack_e) ? NREQ'(1 << m_win) : '0;
    check("fpu_req", 32'(fpu_req), 32'(e == m_issue_e));
    check("ack_o", 32'(ack_o), 32'(ea));
    check("result_o", result_o, m_res);
    check("timeout_o", 32'(timeout_o), 32'(e == m_to_e));
    if (e == m_issue_e) begin
      check("fpu_op_a", fpu_op_a, m_a);
      check("fpu_op_b", fpu_op_b, m_b);
      check("fpu_op", 32'(fpu_op), 32'(m_op));
    end
    if (|ack_o) begin
      for (int k = 0; k < NREQ; k++) if (ack_o[k]) ack_log.push_back(k);
      res_log.push_back(result_o);
      ack_e_log.push_back(e);
    end
    if (fpu_req) req_e_log.push_back(e);
    if (timeout_o) to_count++;
    run = fpu_req ? run + 1 : 0;
    if (run > max_run) max_run = run;
  end

  // ---------------- stimulus ----------------
  task automatic set_op(input int k, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    op_a_i[k*32 +: 32] = a;
    op_b_i[k*32 +: 32] = b;
    op_i[k*3 +: 3]     = op;
  endtask

  task automatic wait_done(input string name, input int budget);
    int c;
    c = 0;
    while ((ops_done[0] < ops_total[0] || ops_done[1] < ops_total[1]) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(name, 32'(c >= budget), 32'd0);
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int n0, r0, c;
    // Reset state.
    @(posedge clk); #1;
    check("rst_ack_o", 32'(ack_o), 32'd0);
    check("rst_result_o", result_o, 32'd0);
    check("rst_fpu_req", 32'(fpu_req), 32'd0);
    check("rst_fpu_op_a", fpu_op_a, 32'd0);
    check("rst_timeout_o", 32'(timeout_o), 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    @(negedge clk); #1;

    // 1: single add on requester 0: 1.0 + 2.0 = 3.0.
    n0 = ack_log.size(); r0 = req_e_log.size();
    set_op(0, 32'h3F80_0000, 32'h4000_0000, FPU_OP_ADD);
    ops_total[0]++;
    wait_done("t1_done", 40);
    check("t1_ack_count", 32'(ack_log.size() - n0), 32'd1);
    check("t1_winner", 32'(ack_log[n0]), 32'd0);
    check("t1_result", res_log[n0], 32'h4040_0000);
    check("t1_req_to_ack", 32'(ack_e_log[n0] - req_e_log[r0]), 32'd3);

    // Spurious ack while idle: no ack_o, result held.
    n0 = ack_log.size();
    spur_req++;
    repeat (4) @(negedge clk); #1;
    check("spur_no_ack", 32'(ack_log.size() - n0), 32'd0);
    check("spur_result_held", result_o, 32'h4040_0000);

    // Reset mid-WAIT: outputs clear immediately, op discarded.
    set_op(0, 32'h40A0_0000, 32'h3F80_0000, FPU_OP_ADD);
    ops_total[0]++;
    c = 0;
    while (!fpu_req && c < 20) begin @(negedge clk); c++; end
    check("rw_saw_fpu_req", 32'(fpu_req), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    ops_total[0] = ops_done[0];
    #1;
    check("rw_ack_o", 32'(ack_o), 32'd0);
    check("rw_result_o", result_o, 32'd0);
    check("rw_fpu_req", 32'(fpu_req), 32'd0);
    check("rw_fpu_op_a", fpu_op_a, 32'd0);
    n0 = ack_log.size();
    repeat (2) @(negedge clk); #1 rst_n = 1'b1;
    repeat (10) @(negedge clk); #1;
    check("rw_no_late_ack", 32'(ack_log.size() - n0), 32'd0);

    // 2: simultaneous requests after reset (ptr 0): 2.0 * 3.0 = 6.0 on both.
    n0 = ack_log.size();
    set_op(0, 32'h4000_0000, 32'h4040_0000, FPU_OP_MUL);
    set_op(1, 32'h4000_0000, 32'h4040_0000, FPU_OP_MUL);
    ops_total[0]++; ops_total[1]++;
    wait_done("t2_done", 60);
    check("t2_first", 32'(ack_log[n0]), 32'd0);
    check("t2_second", 32'(ack_log[n0+1]), 32'd1);
    check("t2_res0", res_log[n0], 32'h40C0_0000);
    check("t2_res1", res_log[n0+1], 32'h40C0_0000);

    // 3: requester 0 held for two ops, requester 1 once: grants 0,1,0.
    pulse_reset();
    n0 = ack_log.size();
    set_op(0, 32'h4040_0000, 32'h3F80_0000, FPU_OP_SUB);   // 3 - 1 = 2
    set_op(1, 32'h40C0_0000, 32'h4000_0000, FPU_OP_DIV);   // 6 / 2 = 3
    ops_total[0] += 2; ops_total[1]++;
    wait_done("t3_done", 80);
    check("t3_g0", 32'(ack_log[n0]), 32'd0);
    check("t3_g1", 32'(ack_log[n0+1]), 32'd1);
    check("t3_g2", 32'(ack_log[n0+2]), 32'd0);
    check("t3_r0", res_log[n0], 32'h4000_0000);
    check("t3_r1", res_log[n0+1], 32'h4040_0000);
    check("t3_r2", res_log[n0+2], 32'h4000_0000);

`ifdef FPU_ARB_TIMEOUT_EN
    // Watchdog: FPU never answers, then a normal op goes through.
    n0 = ack_log.size(); c = to_count;
    fpu_en = 1'b0;
    set_op(1, 32'h3F80_0000, 32'h3F80_0000, FPU_OP_ADD);
    ops_total[1]++;
    wait_done("to_done", 60);
    check("to_pulses", 32'(to_count - c), 32'd1);
    check("to_winner", 32'(ack_log[n0]), 32'd1);
    check("to_result", res_log[n0], 32'h7FC0_0000);
    fpu_en = 1'b1;
    ops_total[1]++;
    wait_done("to_next_done", 40);
    check("to_next_result", res_log[n0+1], 32'h4000_0000);
`endif

    check("fpu_req_max_run", 32'(max_run), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "bench watchdog expired");
  end

endmodule
